// File: rtl/zero_run_detector.sv
// ---------------------------------------------------------------------------
// zero_run_detector
//
// Clocked zero-word detector with a per-bit ignore mask and a consecutive
// zero-run counter. A run is flagged once its length reaches a programmable
// threshold. The block is meant to sit beside datapath ALUs and shifters as a
// status/flag source.
//
// Parameters
//   WIDTH   data word width in bits (>= 1)
//   CNT_W   width of the run counter and threshold (>= 1); the counter
//           saturates at 2^CNT_W-1
//
// Ports
//   clk_i      clock, all state updates on the rising edge
//   rst_i      asynchronous active-high reset
//   en_i       word valid; a_i is only sampled when en_i=1
//   clr_i      synchronous clear of counter, FSM and sticky flag
//   a_i        data word under test
//   mask_i     1 = ignore that bit of a_i in the zero test
//   thresh_i   run length that triggers a hit; 0 disables hits
//   z_o        registered zero result of the last accepted word
//   run_o      current consecutive-zero run length (saturating)
//   hit_o      one-cycle pulse when run_o first reaches thresh_i in a run
//   sticky_o   set with hit_o, held until clr_i or rst_i
//   state_o    debug view of the FSM: 00 IDLE, 01 COUNT, 10 HITD
//
// Priority per edge: rst_i > clr_i > en_i. All outputs come straight from
// flops, so every result appears one cycle after the accepting edge.
// ---------------------------------------------------------------------------
module zero_run_detector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [CNT_W-1:0] thresh_i,
  output logic             z_o,
  output logic [CNT_W-1:0] run_o,
  output logic             hit_o,
  output logic             sticky_o,
  output logic [1:0]       state_o
);

  // -------------------------------------------------------------------------
  // FSM encoding; the codes double as the debug state_o value.
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,  // no run in progress
    ST_COUNT = 2'b01,  // run in progress, threshold not yet reached
    ST_HITD  = 2'b10   // threshold reached, hit already reported for this run
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             hit_q, hit_d;
  logic             sticky_q, sticky_d;

  // -------------------------------------------------------------------------
  // Zero test: a bit only counts against "zero" when it is set and not
  // masked. Works unchanged for WIDTH=1.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] live_bits;
  logic             zero_word;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_live
      assign live_bits[gi] = a_i[gi] & ~mask_i[gi];
    end
  endgenerate

  assign zero_word = ~|live_bits;

  // -------------------------------------------------------------------------
  // Saturating increment of the run length. Holding at RUN_MAX (rather than
  // wrapping) keeps a long run from ever looking like a fresh, short one.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] run_inc;
  logic             thresh_met;

  assign run_inc    = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
  // thresh_i is sampled live each accepting edge; zero disables hits.
  assign thresh_met = (thresh_i != '0) && (run_inc >= thresh_i);

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // Defaults: hold everything, except the hit pulse which self-clears.
    state_d  = state_q;
    z_d      = z_q;
    run_d    = run_q;
    hit_d    = 1'b0;
    sticky_d = sticky_q;

    if (clr_i) begin
      // Clear wins over a simultaneous valid word; a_i is ignored.
      state_d  = ST_IDLE;
      z_d      = 1'b0;
      run_d    = '0;
      sticky_d = 1'b0;
    end else if (en_i) begin
      if (!zero_word) begin
        // An accepted non-zero word is the only data event that ends a run.
        state_d = ST_IDLE;
        z_d     = 1'b0;
        run_d   = '0;
      end else begin
        z_d   = 1'b1;
        run_d = run_inc;
        unique case (state_q)
          ST_IDLE, ST_COUNT: begin
            if (thresh_met) begin
              state_d  = ST_HITD;
              hit_d    = 1'b1;
              sticky_d = 1'b1;
            end else begin
              state_d  = ST_COUNT;
            end
          end
          ST_HITD: begin
            // Already reported this run: no further pulses, even if the
            // run grows or the threshold moves.
            state_d = ST_HITD;
          end
          default: begin
            // Unreachable encoding: recover to a clean idle state.
            state_d = ST_IDLE;
            run_d   = '0;
            z_d     = 1'b0;
          end
        endcase
      end
    end
    // en_i=0 and clr_i=0: gap cycle; everything holds, hit drops.
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      z_q      <= 1'b0;
      run_q    <= '0;
      hit_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      z_q      <= z_d;
      run_q    <= run_d;
      hit_q    <= hit_d;
      sticky_q <= sticky_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs straight from flops
  // -------------------------------------------------------------------------
  assign z_o      = z_q;
  assign run_o    = run_q;
  assign hit_o    = hit_q;
  assign sticky_o = sticky_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_zero_run_detector.sv
// ---------------------------------------------------------------------------
// Testbench for zero_run_detector (WIDTH=8, CNT_W=4).
// Directed vectors with hand-computed expectations. The driver pushes the
// expected post-edge outputs into a queue; a monitor pops one entry after
// each rising edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_zero_run_detector;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_COUNT = 2'b01;
  localparam logic [1:0] S_HITD  = 2'b10;

  logic             clk;
  logic             rst;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] thresh;
  logic             z;
  logic [CNT_W-1:0] run;
  logic             hit;
  logic             sticky;
  logic [1:0]       state;

  zero_run_detector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .clr_i    (clr),
    .a_i      (a),
    .mask_i   (mask),
    .thresh_i (thresh),
    .z_o      (z),
    .run_o    (run),
    .hit_o    (hit),
    .sticky_o (sticky),
    .state_o  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             z;
    logic [CNT_W-1:0] run;
    logic             hit;
    logic             sticky;
    logic [1:0]       state;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if (z !== e.z || run !== e.run || hit !== e.hit ||
        sticky !== e.sticky || state !== e.state) begin
      n_fail++;
      $display("FAIL %s: got z=%0b run=%0d hit=%0b sticky=%0b state=%b, want z=%0b run=%0d hit=%0b sticky=%0b state=%b",
               name, z, run, hit, sticky, state,
               e.z, e.run, e.hit, e.sticky, e.state);
    end else begin
      $display("ok   %s: z=%0b run=%0d hit=%0b sticky=%0b state=%b",
               name, z, run, hit, sticky, state);
    end
  endtask

  // Monitor: one expected entry per edge that the driver scheduled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("vec%0d", n_vec), e);
      end
    end
  end

  // Drive one edge worth of inputs and push the expected result.
  task automatic step(input logic e_en, input logic e_clr,
                      input logic [WIDTH-1:0] e_a, input logic [WIDTH-1:0] e_mask,
                      input logic [CNT_W-1:0] e_th,
                      input logic x_z, input logic [CNT_W-1:0] x_run,
                      input logic x_hit, input logic x_sticky, input logic [1:0] x_state);
    exp_t e;
    @(negedge clk);
    en     = e_en;
    clr    = e_clr;
    a      = e_a;
    mask   = e_mask;
    thresh = e_th;
    e.z      = x_z;
    e.run    = x_run;
    e.hit    = x_hit;
    e.sticky = x_sticky;
    e.state  = x_state;
    exp_q.push_back(e);
    n_step++;
  endtask

  // Watchdog: the run is short; this only guards against a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t zero_e;
    zero_e = '0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; a = '0; mask = '0; thresh = '0;
    repeat (2) @(negedge clk);
    check("reset_state", zero_e);
    rst = 1'b0;

    // Basic run, THRESH=3
    step(1, 0, 8'h00, 8'h00, 4'd3, 1, 4'd1, 0, 0, S_COUNT);
    step(1, 0, 8'h00, 8'h00, 4'd3, 1, 4'd2, 0, 0, S_COUNT);
    step(1, 0, 8'h00, 8'h00, 4'd3, 1, 4'd3, 1, 1, S_HITD);
    step(1, 0, 8'h00, 8'h00, 4'd3, 1, 4'd4, 0, 1, S_HITD);
    step(1, 0, 8'h01, 8'h00, 4'd3, 0, 4'd0, 0, 1, S_IDLE);

    // Mask and EN gaps, THRESH=2
    step(1, 0, 8'h80, 8'h80, 4'd2, 1, 4'd1, 0, 1, S_COUNT);
    step(0, 0, 8'hFF, 8'h00, 4'd2, 1, 4'd1, 0, 1, S_COUNT);
    step(0, 0, 8'hFF, 8'h00, 4'd2, 1, 4'd1, 0, 1, S_COUNT);
    step(0, 0, 8'hFF, 8'h00, 4'd2, 1, 4'd1, 0, 1, S_COUNT);
    step(1, 0, 8'h00, 8'h00, 4'd2, 1, 4'd2, 1, 1, S_HITD);
    step(0, 1, 8'h00, 8'h00, 4'd2, 0, 4'd0, 0, 0, S_IDLE);

    // Mask all ones: any word counts as zero
    step(1, 0, 8'hA5, 8'hFF, 4'd0, 1, 4'd1, 0, 0, S_COUNT);
    step(0, 1, 8'h00, 8'h00, 4'd0, 0, 4'd0, 0, 0, S_IDLE);

    // Saturation, THRESH=0: 20 zero words, RUN stops at 15
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 8'h00, 8'h00, 4'd0, 1, (i > 15) ? 4'd15 : 4'(i), 0, 0, S_COUNT);
    end
    step(0, 1, 8'h00, 8'h00, 4'd0, 0, 4'd0, 0, 0, S_IDLE);

    // Priority: CLR with EN and a zero word while RUN=7, STICKY=1
    for (int i = 1; i <= 7; i++) begin
      step(1, 0, 8'h00, 8'h00, 4'd3, 1, 4'(i), (i == 3) ? 1'b1 : 1'b0,
           (i >= 3) ? 1'b1 : 1'b0, (i >= 3) ? S_HITD : S_COUNT);
    end
    step(1, 1, 8'h00, 8'h00, 4'd3, 0, 4'd0, 0, 0, S_IDLE);

    // Threshold change, THRESH=8 then lowered to 4 during a gap
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 8'h00, 8'h00, 4'd8, 1, 4'(i), 0, 0, S_COUNT);
    end
    step(0, 0, 8'h00, 8'h00, 4'd4, 1, 4'd5, 0, 0, S_COUNT);
    step(1, 0, 8'h00, 8'h00, 4'd4, 1, 4'd6, 1, 1, S_HITD);
    step(1, 0, 8'h00, 8'h00, 4'd4, 1, 4'd7, 0, 1, S_HITD);
    step(1, 0, 8'h00, 8'h00, 4'd4, 1, 4'd8, 0, 1, S_HITD);

    // Non-zero word ends the run, sticky holds; build RUN=5 with sticky
    step(1, 0, 8'h40, 8'h00, 4'd3, 0, 4'd0, 0, 1, S_IDLE);
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 8'h00, 8'h00, 4'd3, 1, 4'(i), (i == 3) ? 1'b1 : 1'b0,
           1'b1, (i >= 3) ? S_HITD : S_COUNT);
    end

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    en  = 1'b0;
    rst = 1'b1;
    #1;
    check("async_reset", zero_e);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 8'h00, 8'h00, 4'd3, 1, 4'd1, 0, 0, S_COUNT);
    step(0, 0, 8'h00, 8'h00, 4'd3, 1, 4'd1, 0, 0, S_COUNT);

    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
